conv_result_sink: RTL and testbench
===================================

// Module: conv_result_sink
// PURPOSE
//  Receiving end of the convolution output stream. Captures output_data/write_enable/parity
//  from the convolution stage into two ping-pong banks, one frame per bank, and lets the
//  RISC-V side drain completed frames word by word. Sits between convolution and the CPU bus.
// PARAMETERS
//  DATA_W  32  sample width, equal to the convolution output_data width
//  DEPTH   64  words per bank (maximum frame length)
//  ADDR_W  6   log2(DEPTH)
// PORTS
//  CLK        in   1       clock, all logic on rising edge
//  RST        in   1       synchronous reset, active-low
//  in_data    in   DATA_W  sample from convolution output_data
//  in_we      in   1       sample strobe from convolution write_enable
//  in_parity  in   1       frame tag from convolution parity; a change marks a new frame
//  rd_en      in   1       read request, one word per asserted cycle
//  rd_data    out  DATA_W  word read, registered
//  rd_valid   out  1       rd_data is valid, one cycle after an accepted rd_en
//  rd_last    out  1       with rd_valid: final word of the frame
//  frame_rdy  out  1       a completed frame is available for draining
//  frame_len  out  ADDR_W+1  length of the frame at the head of the read side (0 if none)
//  overflow   out  1       sticky: a sample was dropped, cleared only by reset
// BEHAVIOUR
//  Reset (RST=0 at edge): both banks EMPTY, wr_bank=0, rd_bank=0, count=0, parity ref unset.
//   rd_data=0, rd_valid=0, rd_last=0, frame_rdy=0, frame_len=0, overflow=0.
//  Bank states: EMPTY -> FILLING -> FULL -> EMPTY. Each bank stores its own length.
//  Write side, per cycle with in_we=1:
//   - First sample after reset latches the parity ref, no frame close.
//   - in_parity != ref and count>0: close wr bank (FULL, len=count), switch to the other bank,
//     write the sample there at addr 0 (count=1), ref<=in_parity.
//   - Otherwise write at addr count, count++. When count reaches DEPTH, close the bank
//     immediately (FULL, len=DEPTH); the next sample opens the other bank.
//   - Target bank not EMPTY: sample dropped, overflow<=1, count unchanged. The parity ref still
//     updates, so the rest of a dropped frame is discarded until the next parity change
//     finds a free bank.
//   - in_we=0: no state change. Frames close only on a parity change or on DEPTH.
//  Read side:
//   - frame_rdy=1 while rd_bank is FULL. frame_len = len of rd_bank, or 0 if it is not FULL.
//   - rd_en while frame_rdy=1: read rd_bank[rd_ptr]. Next cycle rd_valid=1, rd_data=word.
//     rd_ptr++.
//   - On the read of word len-1: rd_last=1 with that rd_valid. The bank becomes EMPTY,
//     rd_bank toggles, rd_ptr=0.
//   - rd_en while frame_rdy=0: ignored. rd_valid=0 next cycle and rd_data holds its value.
//  Simultaneous events:
//   - A release in cycle N is visible to the write side in cycle N, so a sample needing
//     that bank in the same cycle is accepted, not dropped.
//   - Write and read never touch the same bank in the same cycle (FILLING vs FULL).
//  Reset mid-frame discards all stored data. It does not emit partial frames.
//  Memory: two DEPTH x DATA_W arrays, inferred as RAM, synchronous read.
// TESTING
//  T1: after reset, in_parity=1 with 5 writes 0x10..0x14, then parity 0 and one write 0x20
//      -> frame_rdy=1, frame_len=5; 5 rd_en -> rd_data 0x10..0x14, rd_last on 0x14.
//  T2: 64 consecutive writes at constant parity -> bank0 FULL, len=64. The 65th write
//      lands in bank1 addr 0. Read bank0 back intact.
//  T3: fill both banks (parity toggles 1,0,1) with no reads, then a third frame
//      -> its samples are dropped, overflow=1 and stays 1. Banks 0/1 read back correctly.
//  T4: drain bank0, issuing rd_en on the last word in the same cycle a parity change needs
//      bank0 -> the sample is accepted at bank0 addr 0 and overflow stays 0.
//  T5: RST low mid-frame, after 3 writes and 1 read -> all outputs 0, frame_rdy=0.
//      A new frame of 2 writes plus a parity change gives frame_len=2.
//  T6: rd_en with frame_rdy=0 -> rd_valid stays 0 and rd_ptr is unchanged.

Source files
------------

// File: rtl/conv_result_sink.sv
// Ping-pong frame buffer at the convolution output: frames are delimited by parity changes
// or by DEPTH, stored one per bank, and drained word by word by the CPU side.
module conv_result_sink #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic              in_parity,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              frame_rdy,
  output logic [ADDR_W:0]   frame_len,
  output logic              overflow
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  bank_st_t        bank_st     [2];
  bank_st_t        bank_st_nx  [2];
  logic [ADDR_W:0] bank_len    [2];
  logic [ADDR_W:0] bank_len_nx [2];
  logic            wr_bank, wr_bank_nx;
  logic            rd_bank, rd_bank_nx;
  logic [ADDR_W:0] count, count_nx;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nx;
  logic            par_ref, par_ref_nx;
  logic            ref_set, ref_set_nx;
  logic            discard, discard_nx;
  logic            overflow_nx;

  logic            rd_fire, rd_done;
  logic            change, accept, tgt;
  logic            wr_en0, wr_en1;
  logic [ADDR_W-1:0] wr_addr;

  assign frame_rdy = (bank_st[rd_bank] == FULL);
  assign frame_len = frame_rdy ? bank_len[rd_bank] : '0;
  assign rd_fire   = rd_en && frame_rdy;
  assign rd_done   = rd_fire && (({1'b0, rd_ptr} + LEN_ONE) == bank_len[rd_bank]);

  always_comb begin
    bank_st_nx  = bank_st;
    bank_len_nx = bank_len;
    wr_bank_nx  = wr_bank;
    rd_bank_nx  = rd_bank;
    count_nx    = count;
    rd_ptr_nx   = rd_ptr;
    par_ref_nx  = par_ref;
    ref_set_nx  = ref_set;
    discard_nx  = discard;
    overflow_nx = overflow;
    change      = 1'b0;
    accept      = 1'b0;
    tgt         = wr_bank;
    wr_en0      = 1'b0;
    wr_en1      = 1'b0;
    wr_addr     = '0;

    // Read side first: a bank released this cycle is already free for the write side below.
    if (rd_fire) begin
      rd_ptr_nx = rd_ptr + 1'b1;
      if (rd_done) begin
        bank_st_nx[rd_bank] = EMPTY;
        rd_bank_nx          = ~rd_bank;
        rd_ptr_nx           = '0;
      end
    end

    if (in_we) begin
      ref_set_nx = 1'b1;
      par_ref_nx = in_parity;
      change     = ref_set && (in_parity != par_ref);
      if (change && (count != '0)) begin
        bank_st_nx[wr_bank]  = FULL;
        bank_len_nx[wr_bank] = count;
        tgt                  = ~wr_bank;
        wr_bank_nx           = ~wr_bank;
        count_nx             = '0;
        accept               = (bank_st_nx[tgt] != FULL);
      end else if (discard && !change) begin
        accept = 1'b0;
      end else begin
        accept = (bank_st_nx[tgt] != FULL);
      end

      if (accept) begin
        wr_addr         = count_nx[ADDR_W-1:0];
        wr_en0          = ~tgt;
        wr_en1          = tgt;
        bank_st_nx[tgt] = FILLING;
        count_nx        = count_nx + LEN_ONE;
        discard_nx      = 1'b0;
        if (count_nx == DEPTH_L) begin
          bank_st_nx[tgt]  = FULL;
          bank_len_nx[tgt] = DEPTH_L;
          wr_bank_nx       = ~tgt;
          count_nx         = '0;
        end
      end else begin
        // Once a frame starts dropping, the remainder is dropped until a parity change.
        overflow_nx = 1'b1;
        discard_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      par_ref     <= 1'b0;
      ref_set     <= 1'b0;
      discard     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      bank_st     <= bank_st_nx;
      bank_len    <= bank_len_nx;
      wr_bank     <= wr_bank_nx;
      rd_bank     <= rd_bank_nx;
      count       <= count_nx;
      rd_ptr      <= rd_ptr_nx;
      par_ref     <= par_ref_nx;
      ref_set     <= ref_set_nx;
      discard     <= discard_nx;
      overflow    <= overflow_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && wr_en0) mem0[wr_addr] <= in_data;
    if (RST && wr_en1) mem1[wr_addr] <= in_data;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_done;
      if (rd_fire) rd_data <= rd_bank ? mem1[rd_ptr] : mem0[rd_ptr];
    end
  end

endmodule

// File: tb/tb_conv_result_sink.sv
// Directed bench for conv_result_sink: a per-cycle vector table plus hand-written
// sequences for full-bank, overflow, reset and idle-read corner cases.
module tb_conv_result_sink;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_we = 1'b0;
  logic        in_parity = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        frame_rdy;
  logic [6:0]  frame_len;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  conv_result_sink #(.DATA_W(32), .DEPTH(64), .ADDR_W(6)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_we(in_we), .in_parity(in_parity),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .frame_rdy(frame_rdy), .frame_len(frame_len), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        we;
    logic        par;
    logic [31:0] din;
    logic        rd;
    logic        v;
    logic [31:0] dout;
    logic        last;
    logic        rdy;
    logic [6:0]  len;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic we, logic par, logic [31:0] din, logic rd,
                              logic v, logic [31:0] dout, logic last, logic rdy,
                              logic [6:0] len, logic ovf);
    vec_t t;
    t.rst = rst; t.we = we; t.par = par; t.din = din; t.rd = rd;
    t.v = v; t.dout = dout; t.last = last; t.rdy = rdy; t.len = len; t.ovf = ovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic l, input logic r, input logic [6:0] n, input logic o);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(v));
    if (v) check({tag, ".rd_data"}, rd_data, d);
    check({tag, ".rd_last"}, 32'(rd_last), 32'(l));
    check({tag, ".frame_rdy"}, 32'(frame_rdy), 32'(r));
    check({tag, ".frame_len"}, 32'(frame_len), 32'(n));
    check({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  task automatic step(input logic we, input logic par, input logic [31:0] d, input logic rd);
    in_we = we; in_parity = par; in_data = d; rd_en = rd;
    @(posedge CLK);
    #1;
    in_we = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b0; in_we = 1'b0; rd_en = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    check({tag, ".rst.rd_data"}, rd_data, 32'h0);
    check_out({tag, ".rst"}, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0);
  endtask

  initial begin
    // Basic frame (parity change closes a 5-word frame), then the same-cycle release case.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 1, 32'h10 + 32'(i), 0, 0, 0, 0, 0, 7'd0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h20, 0, 0, 0, 0, 1, 7'd5, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h10 + 32'(i), 0, 1, 7'd5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h14, 1, 0, 7'd0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 7'd0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h41, 0, 0, 0, 0, 0, 7'd0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h50, 0, 0, 0, 0, 1, 7'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0,      1, 1, 32'h40, 0, 1, 7'd2, 0));
    tbl.push_back(mk(0, 1, 1, 32'h60, 1, 1, 32'h41, 1, 1, 7'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0,      1, 1, 32'h50, 1, 0, 7'd0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h61, 0, 0, 0, 0, 1, 7'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0,      1, 1, 32'h60, 1, 0, 7'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("vec%0d", i));
      else begin
        step(tbl[i].we, tbl[i].par, tbl[i].din, tbl[i].rd);
        check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].dout, tbl[i].last,
                  tbl[i].rdy, tbl[i].len, tbl[i].ovf);
      end
    end

    // Full bank closes at DEPTH; the 65th sample opens bank1 at address 0.
    do_reset("full");
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 32'h100 + 32'(i), 0);
      if (i == 62) check("full.rdy_early", 32'(frame_rdy), 32'h0);
    end
    check("full.rdy", 32'(frame_rdy), 32'h1);
    check("full.len", 32'(frame_len), 32'd64);
    step(1, 0, 32'h200, 0);
    check("full.ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 1);
      check($sformatf("full.rd%0d", i), rd_data, 32'h100 + 32'(i));
      check($sformatf("full.last%0d", i), 32'(rd_last), 32'(i == 63));
    end
    check("full.rdy_after", 32'(frame_rdy), 32'h0);
    step(1, 1, 32'h300, 0);
    check_out("full.b1", 1'b0, 32'h0, 1'b0, 1'b1, 7'd1, 1'b0);
    step(0, 0, 0, 1);
    check_out("full.b1rd", 1'b1, 32'h200, 1'b1, 1'b0, 7'd0, 1'b0);

    // Both banks full: third frame dropped, overflow sticky, remainder discarded.
    do_reset("ovf");
    step(1, 1, 32'hA0, 0); step(1, 1, 32'hA1, 0); step(1, 1, 32'hA2, 0);
    step(1, 0, 32'hB0, 0); step(1, 0, 32'hB1, 0);
    check_out("ovf.two", 1'b0, 32'h0, 1'b0, 1'b1, 7'd3, 1'b0);
    step(1, 1, 32'hC0, 0);
    check("ovf.set", 32'(overflow), 32'h1);
    step(1, 1, 32'hC1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check_out($sformatf("ovf.a%0d", i), 1'b1, 32'hA0 + 32'(i), 1'(i == 2), 1'b1,
                (i == 2) ? 7'd2 : 7'd3, 1'b1);
    end
    step(0, 0, 0, 1);
    check_out("ovf.b0", 1'b1, 32'hB0, 1'b0, 1'b1, 7'd2, 1'b1);
    step(0, 0, 0, 1);
    check_out("ovf.b1", 1'b1, 32'hB1, 1'b1, 1'b0, 7'd0, 1'b1);
    step(1, 1, 32'hC2, 0);
    step(1, 0, 32'hD0, 0);
    step(1, 1, 32'hE0, 0);
    check_out("ovf.d", 1'b0, 32'h0, 1'b0, 1'b1, 7'd1, 1'b1);
    step(0, 0, 0, 1);
    check_out("ovf.drd", 1'b1, 32'hD0, 1'b1, 1'b0, 7'd0, 1'b1);

    // Reset in the middle of a drain discards everything.
    do_reset("mid");
    step(1, 1, 32'h70, 0); step(1, 1, 32'h71, 0); step(1, 1, 32'h72, 0);
    step(1, 0, 32'h73, 0);
    step(0, 0, 0, 1);
    check_out("mid.rd", 1'b1, 32'h70, 1'b0, 1'b1, 7'd3, 1'b0);
    do_reset("mid2");
    step(1, 1, 32'h80, 0); step(1, 1, 32'h81, 0); step(1, 0, 32'h90, 0);
    check_out("mid.new", 1'b0, 32'h0, 1'b0, 1'b1, 7'd2, 1'b0);
    step(0, 0, 0, 1);
    check_out("mid.r0", 1'b1, 32'h80, 1'b0, 1'b1, 7'd2, 1'b0);
    step(0, 0, 0, 1);
    check_out("mid.r1", 1'b1, 32'h81, 1'b1, 1'b0, 7'd0, 1'b0);

    // Reads with nothing ready are ignored and leave the read pointer alone.
    do_reset("idle");
    step(1, 0, 32'h33, 0);
    step(0, 0, 0, 1);
    check("idle.v0", 32'(rd_valid), 32'h0);
    check("idle.d0", rd_data, 32'h0);
    step(0, 0, 0, 1);
    check("idle.v1", 32'(rd_valid), 32'h0);
    step(1, 0, 32'h34, 0);
    step(1, 1, 32'h35, 0);
    check_out("idle.rdy", 1'b0, 32'h0, 1'b0, 1'b1, 7'd2, 1'b0);
    step(0, 0, 0, 1);
    check_out("idle.r0", 1'b1, 32'h33, 1'b0, 1'b1, 7'd2, 1'b0);
    step(0, 0, 0, 1);
    check_out("idle.r1", 1'b1, 32'h34, 1'b1, 1'b0, 7'd0, 1'b0);
    step(0, 0, 0, 1);
    check("idle.v2", 32'(rd_valid), 32'h0);
    check("idle.hold", rd_data, 32'h34);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
